key_debounce_encoder: RTL and testbench
=======================================

// Module: key_debounce_encoder
// PURPOSE
//   Front end for the 12 push-button switches. Synchronises, debounces and priority-encodes them.
//   Emits one single-cycle key_valid pulse per debounced press, with a 4-bit key code.
//   key_valid/key_value feed the game FSM controller and the number-entry logic.
//   Code map: KEY01..KEY09 -> 1..9, KEY10 ('*') -> 10, KEY11 -> 0, KEY12 ('#') -> 11.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000  stable cycles required on press and on release (10 ms @ 50 MHz); legal min 2
//   REPEAT_DELAY     25000000 hold time before first auto-repeat (AUTO_REPEAT_EN only)
//   REPEAT_PERIOD    10000000 spacing of subsequent auto-repeats (AUTO_REPEAT_EN only)
// PORTS
//   clk        in   1   system clock
//   rst        in   1   asynchronous, active-low reset
//   key01..key12 in 1 each  raw button inputs, active-high (1 = pressed), asynchronous
//   key_valid  out  1   one-cycle pulse: debounced press accepted
//   key_value  out  4   code of last accepted key; valid with key_valid, held until next pulse
//   key_held   out  1   high while FSM in HELD or REL_DB (a key is considered down)
// BEHAVIOUR
//   Reset (rst=0, async): sync FFs=0, state=IDLE, counters=0, key_valid=0, key_value=0, key_held=0.
//   Sync: 2-FF synchroniser per key; all logic below uses synchronised vector s[11:0].
//   Encoder: any=|s; enc = lowest asserted index (key01 highest priority).
//   Counter width = $clog2(max of all cycle params)+1; counter saturates, never wraps.
//   FSM states and transitions:
//     IDLE:    any -> cand<=enc, cnt<=0, PRESS_DB.
//     PRESS_DB: s[cand]==0 or enc!=cand -> IDLE (bounce rejected, no pulse).
//              else cnt++; at cnt==DEBOUNCE_CYCLES-1 -> key_valid=1 for that cycle,
//              key_value<=map(cand), HELD.
//     HELD:    any==0 -> cnt<=0, REL_DB. Extra keys pressed while held: ignored, no pulse.
//     REL_DB:  any==1 -> HELD (release bounce); else cnt++;
//              at cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//   Latency: pin edge to key_valid = 2 (sync) + DEBOUNCE_CYCLES cycles.
//   Exactly one pulse per press; next press accepted only after full debounced release.
//   Simultaneous presses: lowest index wins; encoder change during PRESS_DB restarts via IDLE.
//   key_valid never high two consecutive cycles. Registered output, no combinational path from key inputs.
//   Reset mid-debounce or mid-hold: immediate return to IDLE, no pulse.
//   A key held through reset release is then debounced as a fresh press.
// CONFIGURATION
//   `define KEY_AUTO_REPEAT_EN: in HELD, a second counter runs from 0.
//     At REPEAT_DELAY-1 -> extra key_valid pulse with same key_value.
//     Then one pulse every REPEAT_PERIOD cycles while held.
//     Counter clears on leaving HELD; REL_DB bounce back into HELD restarts from 0.
//   Undefined: no repeat logic, no repeat counter; one pulse per press only.
// TESTING (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6)
//   Reset: hold rst=0 with key05=1 -> all outputs 0.
//     Release rst -> key_valid pulse 10 cycles later, key_value=5.
//   Clean press key11 for 30 cycles -> one pulse, key_value=0, 10 cycles after edge; key_held high until release+8.
//   Bounce: key03 toggled every 3 cycles x4, then held -> no pulse during bounce.
//     One pulse 10 cycles after final edge, value=3.
//   Priority: key12 and key02 rise together -> value=2.
//     key12 pressed while key02 held -> no second pulse.
//   Release bounce: key10 held, released, re-pressed after 4 cycles, released -> single pulse, value=10.
//   Reset mid-PRESS_DB: rst=0 at cnt=5 -> no pulse, state IDLE.
//   With KEY_AUTO_REPEAT_EN: key07 held 60 cycles -> first pulse, repeat after 20 more, then every 6, all value=7.

Source files
------------

// File: rtl/key_debounce_encoder.sv
// key_debounce_encoder: synchronise, debounce and priority-encode 12 push buttons into one-pulse key codes
// Define KEY_AUTO_REPEAT_EN to add auto-repeat pulses while a key stays held.
module key_debounce_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key01,
    input  logic       key02,
    input  logic       key03,
    input  logic       key04,
    input  logic       key05,
    input  logic       key06,
    input  logic       key07,
    input  logic       key08,
    input  logic       key09,
    input  logic       key10,
    input  logic       key11,
    input  logic       key12,
    output logic       key_valid,
    output logic [3:0] key_value,
    output logic       key_held
);
    localparam int MAXP = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                        ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
                        : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam int CW = $clog2(MAXP) + 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    logic [11:0]   raw;
    logic [11:0]   meta_q;
    logic [11:0]   sync_q;
    logic          any;
    logic [3:0]    enc;
    state_t        state_q;
    logic [3:0]    cand_q;
    logic [CW-1:0] cnt_q;
    logic          key_valid_q;
    logic [3:0]    key_value_q;
    logic          key_held_q;

    assign raw = {key12, key11, key10, key09, key08, key07, key06, key05, key04, key03, key02, key01};
    assign any = |sync_q;

    function automatic logic [3:0] map_code(input logic [3:0] idx);
        return (idx == 4'd9) ? 4'd10 : (idx == 4'd10) ? 4'd0 : (idx == 4'd11) ? 4'd11 : idx + 4'd1;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // two-flop synchroniser on every raw button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // priority encoder: lowest asserted index wins
    always_comb begin
        enc = 4'd0;
        for (int i = 11; i >= 0; i--)
            if (sync_q[i]) enc = 4'(i);
    end

    // debounce FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_value_q <= '0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (any) begin
                        cand_q  <= enc;
                        cnt_q   <= '0;
                        state_q <= PRESS_DB;
                    end
                PRESS_DB:
                    if (!sync_q[cand_q] || enc != cand_q) begin
                        state_q <= IDLE;
                    end else if (cnt_q == DB_LAST) begin
                        key_valid_q <= 1'b1;
                        key_value_q <= map_code(cand_q);
                        key_held_q  <= 1'b1;
                        state_q     <= HELD;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                HELD:
                    if (!any) begin
                        cnt_q   <= '0;
                        state_q <= REL_DB;
                    end
                REL_DB:
                    if (any) begin
                        state_q <= HELD;
                    end else if (cnt_q == DB_LAST) begin
                        key_held_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] rpt_q;
    logic          rpt_armed_q;
    logic          rpt_pulse_q;

    // repeat timer, restarted from zero on every entry into HELD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
            rpt_pulse_q <= 1'b0;
        end else if (state_q != HELD || !any) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
            rpt_pulse_q <= 1'b0;
        end else if (rpt_q == (rpt_armed_q ? RP_LAST : RD_LAST)) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b1;
            rpt_pulse_q <= 1'b1;
        end else begin
            rpt_q       <= sat_inc(rpt_q);
            rpt_pulse_q <= 1'b0;
        end
    end

    assign key_valid = key_valid_q | rpt_pulse_q;
`else
    assign key_valid = key_valid_q;
`endif

    assign key_value = key_value_q;
    assign key_held  = key_held_q;
endmodule

// File: tb/tb_key_debounce_encoder.sv
// tb_key_debounce_encoder: directed checks of debounce, encoding, release handling, reset and auto-repeat
module tb_key_debounce_encoder;
    localparam int D = 8;
`ifdef KEY_AUTO_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] k;
    logic        key_valid;
    logic [3:0]  key_value;
    logic        key_held;
    int          tests = 0;
    int          failed = 0;
    int          dbl = 0;
    logic        prev = 1'b0;
    int          np, p1, p2, pl, bp;
    logic [3:0]  pv = 4'd0;

    key_debounce_encoder #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(20), .REPEAT_PERIOD(6)) dut (
        .clk(clk), .rst(rst),
        .key01(k[0]), .key02(k[1]), .key03(k[2]), .key04(k[3]),
        .key05(k[4]), .key06(k[5]), .key07(k[6]), .key08(k[7]),
        .key09(k[8]), .key10(k[9]), .key11(k[10]), .key12(k[11]),
        .key_valid(key_valid), .key_value(key_value), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // key_valid must never stay high on two consecutive cycles
    always @(negedge clk) begin
        if (key_valid && prev) dbl++;
        prev = key_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance n cycles, recording pulse count, first/second/last pulse index and value
    task automatic run(input int n);
        np = 0; p1 = 0; p2 = 0; pl = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (key_valid) begin
                np++;
                if (np == 1) p1 = i;
                if (np == 2) p2 = i;
                pl = i;
                pv = key_value;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        k = '0;
        k[4] = 1'b1;
        repeat (3) tick();
        chk("rst_valid", key_valid, 0);
        chk("rst_value", key_value, 0);
        chk("rst_held", key_held, 0);
        rst = 1'b1;
        run(20);
        chk("k05_pulses", np, 1);
        chk("k05_latency", p1 - 1, 10);
        chk("k05_value", pv, 5);
        chk("k05_held", key_held, 1);
        k = '0;
        run(10);
        chk("k05_held_in_rel", key_held, 1);
        tick();
        chk("k05_released", key_held, 0);
        run(4);

        k[10] = 1'b1;
        run(30);
        chk("k11_pulses", np, 1);
        chk("k11_latency", p1 - 1, 10);
        chk("k11_value", pv, 0);
        chk("k11_held", key_held, 1);
        k = '0;
        run(10);
        chk("k11_rel_pulses", np, REP);
        chk("k11_held_in_rel", key_held, 1);
        tick();
        chk("k11_released", key_held, 0);
        chk("k11_value_kept", key_value, 0);
        run(4);

        bp = 0;
        for (int i = 0; i < 2; i++) begin
            k[2] = 1'b1;
            run(3);
            bp += np;
            k[2] = 1'b0;
            run(3);
            bp += np;
        end
        chk("k03_bounce_pulses", bp, 0);
        k[2] = 1'b1;
        run(20);
        chk("k03_pulses", np, 1);
        chk("k03_latency", p1 - 1, 10);
        chk("k03_value", pv, 3);
        k = '0;
        run(14);
        chk("k03_released", key_held, 0);

        k[11] = 1'b1;
        k[1] = 1'b1;
        run(12);
        chk("prio_pulses", np, 1);
        chk("prio_latency", p1 - 1, 10);
        chk("prio_value", pv, 2);
        k[11] = 1'b0;
        run(3);
        bp = np;
        k[11] = 1'b1;
        run(4);
        bp += np;
        chk("k12_ignored", bp, 0);
        chk("prio_held", key_held, 1);
        chk("prio_value_kept", key_value, 2);
        k = '0;
        run(14);
        chk("prio_released", key_held, 0);

        k[9] = 1'b1;
        run(12);
        chk("k10_pulses", np, 1);
        chk("k10_latency", p1 - 1, 10);
        chk("k10_value", pv, 10);
        k = '0;
        run(4);
        bp = np;
        chk("k10_held_rel_bounce", key_held, 1);
        k[9] = 1'b1;
        run(6);
        bp += np;
        k = '0;
        run(14);
        bp += np;
        chk("k10_single_pulse", bp, 0);
        chk("k10_released", key_held, 0);
        chk("k10_value_kept", key_value, 10);

        k[7] = 1'b1;
        run(8);
        chk("k08_pre_reset_pulses", np, 0);
        #1 rst = 1'b0;
        #1;
        chk("midrst_valid", key_valid, 0);
        chk("midrst_held", key_held, 0);
        chk("midrst_value", key_value, 0);
        k = '0;
        run(2);
        rst = 1'b1;
        run(20);
        chk("midrst_no_pulse", np, 0);
        chk("midrst_idle", key_held, 0);

        k[6] = 1'b1;
        run(60);
        chk("k07_pulses", np, REP ? 6 : 1);
        chk("k07_latency", p1 - 1, 10);
        chk("k07_second", p2, REP ? 31 : 0);
        chk("k07_last", pl, REP ? 55 : 11);
        chk("k07_value", pv, 7);
        k = '0;
        run(14);
        chk("k07_released", key_held, 0);

        chk("no_back_to_back", dbl, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
